// File: rtl/time_setter.sv
// Front-panel minute-preset entry: debounced buttons drive a tens/ones edit FSM that commits BCD digits to the timer.
// Latency: button edge to event is 2 + DEBOUNCE_CYCLES cycles; state/digit updates one cycle after the event; load one cycle after the final mode event.
// Backpressure: none; the timer must accept I1/I0 on the single-cycle load strobe.
module time_setter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] I1,
    output logic [3:0] I0,
    output logic       load,
    output logic       editing,
    output logic [1:0] digit_sel,
    output logic [3:0] edit_d1,
    output logic [3:0] edit_d0
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EDIT_TENS, EDIT_ONES, COMMIT} state_t;

    logic [2:0]    raw;
    logic [2:0]    sync1, sync2, level, ev;
    logic [DW-1:0] db_cnt [3];

    assign raw = {btn_mode, btn_up, btn_down};

    // Counter runs only while the synchronized sample disagrees with the accepted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            ev    <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                ev[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    level[i]  <= sync2[i];
                    ev[i]     <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic ev_mode, ev_up, ev_down, any_ev, do_inc, do_dec;
    assign ev_mode = ev[2];
    assign ev_up   = ev[1];
    assign ev_down = ev[0];
    assign any_ev  = ev_mode | ev_up | ev_down;
    assign do_inc  = ev_up & ~ev_down & ~ev_mode;
    assign do_dec  = ev_down & ~ev_up & ~ev_mode;

    function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic inc, input logic dec);
        logic [3:0] r;
        r = d;
        if (inc)      r = (d >= 4'd9) ? 4'd0 : d + 4'd1;
        else if (dec) r = (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
        return r;
    endfunction

    state_t        state, state_n;
    logic [3:0]    d1_n, d0_n, i1_n, i0_n;
    logic          load_n;
    logic [TW-1:0] to_cnt, to_n;

    always_comb begin
        state_n = state;
        d1_n    = edit_d1;
        d0_n    = edit_d0;
        i1_n    = I1;
        i0_n    = I0;
        load_n  = 1'b0;
        to_n    = to_cnt;
        case (state)
            IDLE: begin
                to_n = '0;
                if (ev_mode) begin
                    d1_n    = I1;
                    d0_n    = I0;
                    state_n = EDIT_TENS;
                end
            end
            EDIT_TENS, EDIT_ONES: begin
                if (ev_mode) begin
                    to_n = '0;
                    if (state == EDIT_TENS) begin
                        state_n = EDIT_ONES;
                    end else begin
                        // Commit is registered on entry so load and I1/I0 appear together in COMMIT.
                        i1_n    = edit_d1;
                        i0_n    = edit_d0;
                        load_n  = 1'b1;
                        state_n = COMMIT;
                    end
                end else if (any_ev) begin
                    to_n = '0;
                    if (state == EDIT_TENS) d1_n = bcd_step(edit_d1, do_inc, do_dec);
                    else                    d0_n = bcd_step(edit_d0, do_inc, do_dec);
                end else if (to_cnt == TO_LAST) begin
                    to_n    = '0;
                    state_n = IDLE;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            COMMIT: begin
                to_n    = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            edit_d1 <= 4'd0;
            edit_d0 <= 4'd0;
            I1      <= 4'd0;
            I0      <= 4'd0;
            load    <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_n;
            edit_d1 <= d1_n;
            edit_d0 <= d0_n;
            I1      <= i1_n;
            I0      <= i0_n;
            load    <= load_n;
            to_cnt  <= to_n;
        end
    end

    assign editing   = (state == EDIT_TENS) || (state == EDIT_ONES);
    assign digit_sel = (state == EDIT_TENS) ? 2'b10 :
                       (state == EDIT_ONES) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: clean, bounced and simultaneous button presses checked against an event-level model.
`timescale 1ns/1ps
module tb_time_setter;

    localparam int DB = 4;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [3:0] I1, I0, edit_d1, edit_d0;
    logic       load, editing;
    logic [1:0] digit_sel;

    always #5 clk = ~clk;

    time_setter #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .I1(I1), .I0(I0), .load(load), .editing(editing), .digit_sel(digit_sel),
        .edit_d1(edit_d1), .edit_d0(edit_d0)
    );

    int n_chk = 0, n_fail = 0, load_cnt = 0;
    // Model: m_st 0 = idle, 1 = editing tens, 2 = editing ones.
    int m_st = 0, m_d1 = 0, m_d0 = 0, m_i1 = 0, m_i0 = 0, m_loads = 0;

    always @(negedge clk) if (load === 1'b1) load_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("I1", 32'(I1), m_i1);
        chk("I0", 32'(I0), m_i0);
        chk("editing", 32'(editing), (m_st != 0) ? 1 : 0);
        chk("digit_sel", 32'(digit_sel), (m_st == 1) ? 2 : (m_st == 2) ? 1 : 0);
        chk("load_idle", 32'(load), 0);
        chk("load_count", load_cnt, m_loads);
        if (m_st != 0) begin
            chk("edit_d1", 32'(edit_d1), m_d1);
            chk("edit_d0", 32'(edit_d0), m_d0);
        end
    endtask

    task automatic model_ev(input bit m, input bit u, input bit d);
        int delta;
        delta = 0;
        if (m) begin
            if (m_st == 0) begin
                m_d1 = m_i1; m_d0 = m_i0; m_st = 1;
            end else if (m_st == 1) begin
                m_st = 2;
            end else begin
                m_i1 = m_d1; m_i0 = m_d0; m_loads++; m_st = 0;
            end
        end else begin
            if (u && !d) delta = 1;
            if (d && !u) delta = 9;
            if (m_st == 1) m_d1 = (m_d1 + delta) % 10;
            if (m_st == 2) m_d0 = (m_d0 + delta) % 10;
        end
    endtask

    task automatic release_and_settle(input bit m, input bit u, input bit d);
        repeat (10) @(negedge clk);
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        repeat (12) @(negedge clk);
        model_ev(m, u, d);
        check_all();
    endtask

    task automatic press(input bit m, input bit u, input bit d);
        @(negedge clk);
        btn_mode = m; btn_up = u; btn_down = d;
        release_and_settle(m, u, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        if (n >= 80) m_st = 0;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_st = 0; m_d1 = 0; m_d0 = 0; m_i1 = 0; m_i0 = 0;
        check_all();
        chk("rst_edit_d1", 32'(edit_d1), 0);
        chk("rst_edit_d0", 32'(edit_d0), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        // Reset values, then short glitches that must not register.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            btn_mode = (b == 0); btn_up = (b == 1); btn_down = (b == 2);
            repeat (2) @(negedge clk);
            btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
            repeat (8) @(negedge clk);
            check_all();
        end

        // Full edit: tens up x3, ones down x1, commit 39.
        press(1, 0, 0);
        repeat (3) press(0, 1, 0);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        chk("commit_I1", 32'(I1), 3);
        chk("commit_I0", 32'(I0), 9);

        // Tens wrap in both directions.
        press(1, 0, 0);
        repeat (3) press(0, 0, 1);
        press(0, 0, 1);
        chk("wrap_down", 32'(edit_d1), 9);
        press(0, 1, 0);
        chk("wrap_up", 32'(edit_d1), 0);
        press(1, 0, 0);
        press(1, 0, 0);

        // Timeout abandons the edit.
        press(1, 0, 0);
        press(0, 1, 0);
        idle(30);
        idle(100);

        // Bounce then hold, then mode+up together.
        press(1, 0, 0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            btn_up = ~btn_up;
            #5;
        end
        btn_up = 1'b1;
        @(negedge clk);
        release_and_settle(0, 1, 0);
        press(1, 1, 0);
        press(0, 0, 1);
        press(1, 0, 0);

        // Reset during EDIT_ONES.
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        do_reset();
        check_all();

        // Random button sequences.
        repeat (120) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: press(1, 0, 0);
                3, 4:    press(0, 1, 0);
                5, 6:    press(0, 0, 1);
                7:       press(0, 1, 1);
                8:       press(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                default: idle(($urandom_range(0, 1) == 1) ? 100 : 20);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
